seg_mux_driver: RTL

- Drives a NUM_DIGITS common-anode/cathode multiplexed seven-segment display from a packed array of 5-bit digit codes.
- Per-digit decimal points, leading-zero blanking and a frame-synchronous shadow register prevent tearing.
- Optional hex glyphs are set at compile time.
- Sits between the game score/timer logic and the board display pins; successor to the single-digit decoder.

---
 rtl/seg_mux_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg_mux_driver.sv
// seg_mux_driver
//   Time-multiplexed seven-segment display driver. Digit codes and decimal
//   points are captured into a shadow register on `load`, then copied into
//   the live display register only at a frame boundary so a scan never mixes
//   old and new digits.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous active-low reset
//   digits     5-bit code per digit, digit 0 in bits [4:0] (rightmost)
//   dp         decimal-point request per digit
//   load       one-cycle strobe capturing digits/dp into the shadow
//   blank_lz   1 = suppress leading zeros (digit 0 always shown)
//   seg_out    {dp, g..a}, active-high, registered
//   an_out     one-hot digit enable, active-high, registered
//   frame_done one-cycle pulse after the last slot of each scan
//
// Compile-time option
//   SEG_HEX_EN : codes 10..15 render A,b,C,d,E,F; otherwise they are blank.
module seg_mux_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [5*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]                cnt_q, cnt_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic                         pending_q, pending_d;
   logic [NUM_DIGITS-1:0][4:0]   shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0][4:0]   disp_dig_q, disp_dig_d;
   logic [NUM_DIGITS-1:0]        disp_dp_q, disp_dp_d;
   logic [7:0]                   seg_q, seg_d;
   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic                         fd_q, fd_d;

   logic                         frame_end;
   logic                         nz_hi;
   logic                         lz_blank;
   logic [4:0]                   cur_code;

   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'd0:    g = 7'h3F;
         5'd1:    g = 7'h06;
         5'd2:    g = 7'h5B;
         5'd3:    g = 7'h4F;
         5'd4:    g = 7'h66;
         5'd5:    g = 7'h6D;
         5'd6:    g = 7'h7D;
         5'd7:    g = 7'h07;
         5'd8:    g = 7'h7F;
         5'd9:    g = 7'h6F;
`ifdef SEG_HEX_EN
         5'd10:   g = 7'h77;
         5'd11:   g = 7'h7C;
         5'd12:   g = 7'h39;
         5'd13:   g = 7'h5E;
         5'd14:   g = 7'h79;
         5'd15:   g = 7'h71;
`endif
         5'd17:   g = 7'h40;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   always_comb begin
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      shadow_dig_d = shadow_dig_q;
      shadow_dp_d  = shadow_dp_q;
      disp_dig_d   = disp_dig_q;
      disp_dp_d    = disp_dp_q;

      frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

      // Scan position
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Commit reads the shadow before any coincident load overwrites it;
      // a coincident load then re-arms pending for the next frame.
      if (frame_end && pending_q) begin
         disp_dig_d = shadow_dig_q;
         disp_dp_d  = shadow_dp_q;
         pending_d  = 1'b0;
      end
      if (load) begin
         shadow_dig_d = digits;
         shadow_dp_d  = dp;
         pending_d    = 1'b1;
      end

      // Leading-zero test: any non-zero code at or above the current slot
      cur_code = disp_dig_q[idx_q];
      nz_hi    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((IW'(k) >= idx_q) && (disp_dig_q[k] != 5'd0)) nz_hi = 1'b1;
      end
      lz_blank = blank_lz && (idx_q != '0) && !nz_hi;

      seg_d = {disp_dp_q[idx_q], lz_blank ? 7'h00 : glyph(cur_code)};

      // First cycle of each slot keeps all anodes off (anti-ghosting gap)
      an_d = '0;
      if (cnt_q != '0) an_d[idx_q] = 1'b1;

      fd_d = frame_end;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         shadow_dig_q <= '0;
         shadow_dp_q  <= '0;
         disp_dig_q   <= '0;
         disp_dp_q    <= '0;
         seg_q        <= 8'h3F;
         an_q         <= '0;
         fd_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_dig_q   <= disp_dig_d;
         disp_dp_q    <= disp_dp_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         fd_q         <= fd_d;
      end
   end

   assign seg_out    = seg_q;
   assign an_out     = an_q;
   assign frame_done = fd_q;

endmodule
